// File: rtl/tile_pkg.sv
// tile_pkg: shared colour type, default colours and tile-geometry helpers for tile layers
package tile_pkg;
  typedef logic [23:0] rgb_t;
  localparam rgb_t DEF_BG_COLOR = 24'h000000;
  localparam rgb_t DEF_BORDER_COLOR = 24'hFFFFFF;
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
  function automatic int code_w(input int tiles_per_reg);
    return 32 / tiles_per_reg;
  endfunction
  function automatic int n_per_row(input int width, input int sprite, input int tiles_per_reg);
    return width / (sprite * tiles_per_reg);
  endfunction
  localparam int CODE_W = code_w(4);
  localparam int N_PER_ROW = n_per_row(1920, 40, 4);
endpackage

// File: rtl/tile_pos_counter.sv
// tile_pos_counter: tile-grid position counters and tile-map word addressing from pixel timing
module tile_pos_counter
  import tile_pkg::*;
#(
  parameter int WIDTH = 1920,
  parameter int HEIGHT = 1080,
  parameter int SPRITE_SIZE = 40,
  parameter int TILES_PER_REG = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vde_in,
  input  logic vsync_in,
  output logic [clog2w(TILES_PER_REG)-1:0] slot,
  output logic off_map,
  output logic border,
  output logic [8:0] map_addr
);
  localparam int NPR = n_per_row(WIDTH, SPRITE_SIZE, TILES_PER_REG);
  localparam int N_ROWS = (HEIGHT + SPRITE_SIZE - 1) / SPRITE_SIZE;
  localparam int SLOT_W = clog2w(TILES_PER_REG);
  localparam int PX_W = clog2w(SPRITE_SIZE);
  localparam int COL_W = clog2w(NPR + 1);
  localparam int ROW_W = clog2w(N_ROWS + 1);
  logic [PX_W-1:0] px, py;
  logic [COL_W-1:0] word_col, col_c;
  logic [ROW_W-1:0] word_row, row_c;
  logic vde_q, vsync_q, px_wrap, slot_wrap, py_wrap;
  logic [8:0] addr_q;
  assign px_wrap = px == PX_W'(SPRITE_SIZE - 1);
  assign slot_wrap = slot == SLOT_W'(TILES_PER_REG - 1);
  assign py_wrap = py == PX_W'(SPRITE_SIZE - 1);
  assign off_map = (word_col == COL_W'(NPR)) || (word_row == ROW_W'(N_ROWS));
  assign border = (px == '0) || (py == '0);
  // saturated counters point one past the map; keep the address on the last real word
  assign col_c = word_col == COL_W'(NPR) ? COL_W'(NPR - 1) : word_col;
  assign row_c = word_row == ROW_W'(N_ROWS) ? ROW_W'(N_ROWS - 1) : word_row;
  assign map_addr = vde_in ? 9'(row_c) * 9'(NPR) + 9'(col_c) : addr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px <= '0;
      slot <= '0;
      word_col <= '0;
      py <= '0;
      word_row <= '0;
      vde_q <= 1'b0;
      vsync_q <= 1'b0;
      addr_q <= '0;
    end else begin
      vde_q <= vde_in;
      vsync_q <= vsync_in;
      if (vde_in) addr_q <= map_addr;
      if (vsync_in && !vsync_q) begin
        px <= '0;
        slot <= '0;
        word_col <= '0;
        py <= '0;
        word_row <= '0;
      end else if (vde_in) begin
        px <= px_wrap ? '0 : px + 1'b1;
        if (px_wrap) slot <= slot_wrap ? '0 : slot + 1'b1;
        if (px_wrap && slot_wrap && word_col != COL_W'(NPR)) word_col <= word_col + 1'b1;
      end else if (vde_q) begin
        px <= '0;
        slot <= '0;
        word_col <= '0;
        py <= py_wrap ? '0 : py + 1'b1;
        if (py_wrap && word_row != ROW_W'(N_ROWS)) word_row <= word_row + 1'b1;
      end
    end
  end
endmodule

// File: rtl/tile_pixel_pipe.sv
// tile_pixel_pipe: 2-stage tile renderer mapping tile-map codes through a palette onto RGB
// Define TILE_BORDER_EN to draw a BORDER_COLOR grid on tile edges.
module tile_pixel_pipe
  import tile_pkg::*;
#(
  parameter int WIDTH = 1920,
  parameter int HEIGHT = 1080,
  parameter int SPRITE_SIZE = 40,
  parameter int TILES_PER_REG = 4,
  parameter int PAL_DEPTH = 16,
  parameter rgb_t BG_COLOR = DEF_BG_COLOR,
  parameter rgb_t BORDER_COLOR = DEF_BORDER_COLOR
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vde_in,
  input  logic hsync_in,
  input  logic vsync_in,
  output logic [8:0] map_addr,
  input  logic [31:0] map_data,
  input  logic pal_we,
  input  logic [$clog2(PAL_DEPTH)-1:0] pal_addr,
  input  logic [23:0] pal_data,
  output logic [7:0] R,
  output logic [7:0] G,
  output logic [7:0] B,
  output logic vde_out,
  output logic hsync_out,
  output logic vsync_out
);
`ifdef TILE_BORDER_EN
  localparam bit BORDER_ON = 1'b1;
`else
  localparam bit BORDER_ON = 1'b0;
`endif
  localparam int CW = code_w(TILES_PER_REG);
  localparam int IDX_W = $clog2(PAL_DEPTH);
  localparam int SLOT_W = clog2w(TILES_PER_REG);
  logic [SLOT_W-1:0] slot, s1_slot;
  logic off_map, border, s1_vde, s1_hsync, s1_vsync, s1_off, s1_border;
  logic [CW-1:0] code;
  rgb_t pal [PAL_DEPTH];
  rgb_t color;
  tile_pos_counter #(
    .WIDTH(WIDTH),
    .HEIGHT(HEIGHT),
    .SPRITE_SIZE(SPRITE_SIZE),
    .TILES_PER_REG(TILES_PER_REG)
  ) u_pos (
    .clk(clk),
    .rst_n(rst_n),
    .vde_in(vde_in),
    .vsync_in(vsync_in),
    .slot(slot),
    .off_map(off_map),
    .border(border),
    .map_addr(map_addr)
  );
  assign code = map_data[s1_slot*CW +: CW];
  // palette is read before this cycle's write lands, so a same-index write shows from the next pixel
  assign color = !s1_vde ? '0
               : (BORDER_ON && s1_border) ? BORDER_COLOR
               : (s1_off || code == '0) ? BG_COLOR
               : pal[code[IDX_W-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s1_vde, s1_hsync, s1_vsync, s1_off, s1_border} <= '0;
      s1_slot <= '0;
      {R, G, B} <= '0;
      {vde_out, hsync_out, vsync_out} <= '0;
    end else begin
      {s1_vde, s1_hsync, s1_vsync, s1_off, s1_border} <= {vde_in, hsync_in, vsync_in, off_map, border};
      s1_slot <= slot;
      {R, G, B} <= color;
      {vde_out, hsync_out, vsync_out} <= {s1_vde, s1_hsync, s1_vsync};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < PAL_DEPTH; i++) pal[i] <= '0;
    else if (pal_we) pal[pal_addr] <= pal_data;
  end
endmodule
